// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial ALU blocks: state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
    logic [CNT_W-1:0]   cnt;
    logic               brw, a_msb, b_msb;
    logic               bit_d, bit_bout;
    logic               last_bit, accept;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // start is honoured only when not shifting, so operands in flight are never disturbed
    assign accept   = start && (state != SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= borrow_in;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {bit_d, res_sr[WIDTH-1:1]};
            brw    <= bit_bout;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                // The final bit is the result MSB, so it decides the overflow.
                diff       <= {bit_d, res_sr[WIDTH-1:1]};
                borrow_out <= bit_bout;
                overflow   <= (a_msb != b_msb) && (bit_d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out, overflow;
    logic [W-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a - b - bin with plain integer arithmetic.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int full;
        full = int'(av) - int'(bv) - int'(bi);
        d  = full[W-1:0];
        bo = (int'(av) < int'(bv) + int'(bi));
        ov = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
    endtask

    // One operation; inject_at > 0 pulses an extra start (a=9, b=3) at that edge count.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input int inject_at);
        logic [W-1:0] ed;
        logic eb, eo;
        int edges, busy_cnt;
        model(av, bv, bi, ed, eb, eo);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            if (edges == inject_at) begin
                a = 8'd9; b = 8'd3; borrow_in = 1'b0; start = 1'b1;
            end
            tick();
            start = 1'b0;
            edges++;
        end
        // Counting the accepting edge, done appears after WIDTH+1 edges.
        check({tag, " done_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(edges), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " borrow"}, 32'(borrow_out), 32'(eb));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " diff_held"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        logic [W-1:0] ed;
        logic eb, eo;
        int edges;
        logic seen;

        rst = 1'b1;
        start = 1'b1;
        a = 8'hAA; b = 8'h55;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();

        run_op("37-21", 8'd37, 8'd21, 1'b0, 0);
        run_op("0-1", 8'd0, 8'd1, 1'b0, 0);
        run_op("80-01", 8'h80, 8'h01, 1'b0, 0);
        run_op("7F-FF", 8'h7F, 8'hFF, 1'b0, 0);
        run_op("5-5-1 inject", 8'd5, 8'd5, 1'b1, 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_restart busy", 32'(busy), 32'd0);
            check("no_restart diff", 32'(diff), 32'hFF);
        end

        // Back-to-back: start held high through DONE.
        a = 8'd200; b = 8'd100; borrow_in = 1'b0; start = 1'b1;
        tick();
        a = 8'd31; b = 8'd1;
        edges = 1;
        while (!done && edges < 40) begin tick(); edges++; end
        check("b2b first latency", 32'(edges), 32'(W + 1));
        check("b2b first diff", 32'(diff), 32'd100);
        tick();
        start = 1'b0;
        check("b2b restart busy", 32'(busy), 32'd1);
        edges = 1;
        while (!done && edges < 40) begin
            check("b2b stable diff", 32'(diff), 32'd100);
            tick();
            edges++;
        end
        check("b2b spacing", 32'(edges), 32'(W + 1));
        check("b2b second diff", 32'(diff), 32'd30);
        check("b2b second borrow", 32'(borrow_out), 32'd0);
        tick();

        // Reset in the middle of an operation.
        a = 8'd37; b = 8'd21; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst diff", 32'(diff), 32'd0);
        check("midrst borrow", 32'(borrow_out), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("midrst no_done", 32'(seen), 32'd0);
        run_op("after_rst 37-21", 8'd37, 8'd21, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic rbi;
            ra = W'($urandom);
            rb = W'($urandom);
            rbi = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rbi, (i % 3 == 0) ? 1 + (i % 7) : 0);
        end

        model(8'd0, 8'd0, 1'b1, ed, eb, eo);
        run_op("0-0-1", 8'd0, 8'd0, 1'b1, 0);
        check("0-0-1 model", 32'(diff), 32'(ed));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
